// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/acknowledge bus between the fetch unit and instruction memory.
// A request is held stable from imem_req rising until the cycle imem_ack pulses.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues word fetches, buffers one instruction while IF/ID stalls,
// and squashes in-flight fetches on a branch redirect.
//
// state     | meaning
// S_REQ     | request outstanding at PC; ack presents the instruction
// S_HOLD    | instruction buffered, IF/ID stalled, no request
// S_DISCARD | killed request outstanding at kill_addr; its ack is dropped
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      IF_ID_en,
  input  logic                      branch_taken,
  input  logic [31:0]               branch_target,
  instr_fetch_unit_if.master        imem,
  output logic [31:0]               instruction_IF_out,
  output logic [31:0]               NPC_IF_out
);

  typedef enum logic [1:0] {
    S_REQ     = 2'd0,
    S_HOLD    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] kill_addr_q, kill_addr_d;
  logic [31:0] buf_instr_q, buf_instr_d;
  logic [31:0] buf_npc_q, buf_npc_d;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_pc;
  logic        unused_target_lsbs;

  assign pc_plus4           = pc_q + 32'd4;
  assign redirect_pc        = {branch_target[31:2], 2'b00};
  assign unused_target_lsbs = ^branch_target[1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_REQ;
      pc_q        <= PC_INIT;
      kill_addr_q <= PC_INIT;
      buf_instr_q <= 32'b0;
      buf_npc_q   <= 32'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_addr_q <= kill_addr_d;
      buf_instr_q <= buf_instr_d;
      buf_npc_q   <= buf_npc_d;
    end
  end

  // Outputs are gated by reset so the bus is idle and IF/ID sees bubbles while reset is low.
  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    kill_addr_d        = kill_addr_q;
    buf_instr_d        = buf_instr_q;
    buf_npc_d          = buf_npc_q;
    imem.imem_req      = 1'b0;
    imem.imem_addr     = pc_q;
    instruction_IF_out = 32'b0;
    NPC_IF_out         = 32'b0;

    if (reset) begin
      case (state_q)
        S_REQ: begin
          imem.imem_req = 1'b1;
          if (branch_taken) begin
            pc_d = redirect_pc;
            if (!imem.imem_ack) begin
              kill_addr_d = pc_q;
              state_d     = S_DISCARD;
            end
          end else if (imem.imem_ack) begin
            instruction_IF_out = imem.imem_rdata;
            NPC_IF_out         = pc_plus4;
            pc_d               = pc_plus4;
            if (IF_ID_en) begin
              buf_instr_d = imem.imem_rdata;
              buf_npc_d   = pc_plus4;
              state_d     = S_HOLD;
            end
          end
        end

        S_HOLD: begin
          if (branch_taken) begin
            pc_d        = redirect_pc;
            buf_instr_d = 32'b0;
            buf_npc_d   = 32'b0;
            state_d     = S_REQ;
          end else begin
            instruction_IF_out = buf_instr_q;
            NPC_IF_out         = buf_npc_q;
            if (!IF_ID_en) state_d = S_REQ;
          end
        end

        S_DISCARD: begin
          imem.imem_req  = 1'b1;
          imem.imem_addr = kill_addr_q;
          if (branch_taken) pc_d = redirect_pc;
          if (imem.imem_ack) state_d = S_REQ;
        end

        default: state_d = S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scenario bench for instr_fetch_unit: expected instructions are queued as the memory
// responds and compared when IF/ID accepts them.
module tb_instr_fetch_unit;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] npc;
  } exp_t;

  logic        clk;
  logic        rst1, rst2;
  logic        IF_ID_en, branch_taken, ack;
  logic [31:0] branch_target, rdata;
  logic [31:0] instr1, npc1, instr2, npc2;

  exp_t sb[$];
  exp_t exp_v;
  int   checks = 0;
  int   errors = 0;

  instr_fetch_unit_if bus1 ();
  instr_fetch_unit_if bus2 ();

  assign bus1.imem_ack   = ack;
  assign bus1.imem_rdata = rdata;
  assign bus2.imem_ack   = ack;
  assign bus2.imem_rdata = rdata;

  instr_fetch_unit dut1 (
    .clk(clk), .reset(rst1), .IF_ID_en(IF_ID_en), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem(bus1.master),
    .instruction_IF_out(instr1), .NPC_IF_out(npc1)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset(rst2), .IF_ID_en(IF_ID_en), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem(bus2.master),
    .instruction_IF_out(instr2), .NPC_IF_out(npc2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic a, input logic [31:0] rd,
                       input logic br, input logic [31:0] tgt);
    IF_ID_en = en; ack = a; rdata = rd; branch_taken = br; branch_target = tgt;
  endtask

  task automatic do_reset();
    next_cycle();
    rst1 = 1'b0;
    drive(0, 0, 0, 0, 0);
    sb.delete();
    next_cycle();
    rst1 = 1'b1;
  endtask

  task automatic test_reset();
    rst1 = 1'b0;
    rst2 = 1'b0;
    drive(0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();
    drive(0, 1, 32'hDEAD_BEEF, 0, 0);
    #1;
    checks++; if (bus1.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", bus1.imem_req); end
    checks++; if (instr1 !== 32'b0 || npc1 !== 32'b0) begin errors++; $display("FAIL rst_out: got %h/%h expected 0/0", instr1, npc1); end
    next_cycle();
    drive(0, 0, 0, 0, 0);
    rst1 = 1'b1;
    #1;
    checks++; if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_release: got req %b addr %h expected 1/00000000", bus1.imem_req, bus1.imem_addr); end
  endtask

  task automatic test_sequential();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 32'hA000_0000 + i, 0, 0);
      sb.push_back({32'hA000_0000 + i, 32'(4 * (i + 1))});
      #1;
      checks++; if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL seq_addr%0d: got req %b addr %h expected 1/%h", i, bus1.imem_req, bus1.imem_addr, 32'(4 * i)); end
      exp_v = sb.pop_front();
      checks++; if (instr1 !== exp_v.instr || npc1 !== exp_v.npc) begin errors++; $display("FAIL seq_out%0d: got %h/%h expected %h/%h", i, instr1, npc1, exp_v.instr, exp_v.npc); end
      next_cycle();
    end
    drive(0, 0, 0, 0, 0);
    #1;
    checks++; if (instr1 !== 32'b0 || npc1 !== 32'b0 || bus1.imem_addr !== 32'h10) begin errors++; $display("FAIL seq_bubble: got %h/%h addr %h expected 0/0 addr 00000010", instr1, npc1, bus1.imem_addr); end
  endtask

  task automatic test_hold();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 32'hB000_0000 + i, 0, 0);
      next_cycle();
    end
    drive(1, 1, 32'hC0DE_0008, 0, 0);
    sb.push_back({32'hC0DE_0008, 32'h0000_000C});
    #1;
    checks++; if (bus1.imem_addr !== 32'h8 || instr1 !== sb[0].instr || npc1 !== sb[0].npc) begin errors++; $display("FAIL hold_ack: got addr %h out %h/%h expected 00000008 %h/%h", bus1.imem_addr, instr1, npc1, sb[0].instr, sb[0].npc); end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drive(i == 2 ? 1'b0 : 1'b1, 1, 32'h5555_0000 + i, 0, 0);
      #1;
      checks++; if (bus1.imem_req !== 1'b0) begin errors++; $display("FAIL hold_req%0d: got %b expected 0", i, bus1.imem_req); end
      checks++; if (instr1 !== sb[0].instr || npc1 !== sb[0].npc) begin errors++; $display("FAIL hold_out%0d: got %h/%h expected %h/%h", i, instr1, npc1, sb[0].instr, sb[0].npc); end
    end
    exp_v = sb.pop_front();
    next_cycle();
    drive(0, 1, 32'hC0DE_000C, 0, 0);
    sb.push_back({32'hC0DE_000C, 32'h0000_0010});
    #1;
    checks++; if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 32'hC) begin errors++; $display("FAIL hold_resume: got req %b addr %h expected 1/0000000c", bus1.imem_req, bus1.imem_addr); end
    exp_v = sb.pop_front();
    checks++; if (instr1 !== exp_v.instr || npc1 !== exp_v.npc) begin errors++; $display("FAIL hold_resume_out: got %h/%h expected %h/%h", instr1, npc1, exp_v.instr, exp_v.npc); end
  endtask

  task automatic test_branch_wait();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 32'hE000_0000 + i, 0, 0);
      next_cycle();
    end
    for (int c = 0; c < 4; c++) begin
      if (c == 1) drive(0, 0, 0, 1, 32'h0000_0100);
      else if (c == 3) drive(0, 1, 32'hBAD0_BAD0, 0, 0);
      else drive(0, 0, 0, 0, 0);
      #1;
      checks++; if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 32'h10) begin errors++; $display("FAIL bw_addr%0d: got req %b addr %h expected 1/00000010", c, bus1.imem_req, bus1.imem_addr); end
      checks++; if (instr1 !== 32'b0 || npc1 !== 32'b0) begin errors++; $display("FAIL bw_bubble%0d: got %h/%h expected 0/0", c, instr1, npc1); end
      next_cycle();
    end
    drive(0, 1, 32'hF00D_0100, 0, 0);
    sb.push_back({32'hF00D_0100, 32'h0000_0104});
    #1;
    checks++; if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 32'h100) begin errors++; $display("FAIL bw_target: got req %b addr %h expected 1/00000100", bus1.imem_req, bus1.imem_addr); end
    exp_v = sb.pop_front();
    checks++; if (instr1 !== exp_v.instr || npc1 !== exp_v.npc) begin errors++; $display("FAIL bw_out: got %h/%h expected %h/%h", instr1, npc1, exp_v.instr, exp_v.npc); end
  endtask

  task automatic test_branch_ack();
    do_reset();
    drive(0, 1, 32'h1234_5678, 1, 32'h0000_0203);
    #1;
    checks++; if (instr1 !== 32'b0 || npc1 !== 32'b0) begin errors++; $display("FAIL ba_bubble: got %h/%h expected 0/0", instr1, npc1); end
    next_cycle();
    drive(0, 1, 32'h2222_0200, 0, 0);
    sb.push_back({32'h2222_0200, 32'h0000_0204});
    #1;
    checks++; if (bus1.imem_addr !== 32'h200) begin errors++; $display("FAIL ba_addr: got %h expected 00000200", bus1.imem_addr); end
    exp_v = sb.pop_front();
    checks++; if (instr1 !== exp_v.instr || npc1 !== exp_v.npc) begin errors++; $display("FAIL ba_out: got %h/%h expected %h/%h", instr1, npc1, exp_v.instr, exp_v.npc); end
  endtask

  task automatic test_discard_branch();
    do_reset();
    drive(0, 0, 0, 1, 32'h0000_0040);
    next_cycle();
    drive(0, 0, 0, 1, 32'h0000_0080);
    #1;
    checks++; if (bus1.imem_addr !== 32'h0 || bus1.imem_req !== 1'b1) begin errors++; $display("FAIL db_kill_addr: got req %b addr %h expected 1/00000000", bus1.imem_req, bus1.imem_addr); end
    next_cycle();
    drive(0, 1, 32'h7777_7777, 0, 0);
    #1;
    checks++; if (instr1 !== 32'b0 || npc1 !== 32'b0) begin errors++; $display("FAIL db_drop: got %h/%h expected 0/0", instr1, npc1); end
    next_cycle();
    drive(0, 0, 0, 0, 0);
    #1;
    checks++; if (bus1.imem_addr !== 32'h80) begin errors++; $display("FAIL db_target: got %h expected 00000080", bus1.imem_addr); end
  endtask

  task automatic test_hold_branch();
    do_reset();
    drive(1, 1, 32'h9999_0000, 0, 0);
    next_cycle();
    drive(1, 0, 0, 1, 32'h0000_0400);
    #1;
    checks++; if (instr1 !== 32'b0 || npc1 !== 32'b0 || bus1.imem_req !== 1'b0) begin errors++; $display("FAIL hb_bubble: got %h/%h req %b expected 0/0 req 0", instr1, npc1, bus1.imem_req); end
    next_cycle();
    drive(0, 0, 0, 0, 0);
    #1;
    checks++; if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 32'h400) begin errors++; $display("FAIL hb_target: got req %b addr %h expected 1/00000400", bus1.imem_req, bus1.imem_addr); end
  endtask

  task automatic test_wrap();
    rst1 = 1'b0;
    next_cycle();
    rst2 = 1'b1;
    sb.delete();
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      drive(0, 1, 32'h3300_0000 + i, 0, 0);
      sb.push_back({32'h3300_0000 + i, 32'(4 * i)});
      #1;
      checks++; if (bus2.imem_addr !== 32'hFFFF_FFFC + 32'(4 * i)) begin errors++; $display("FAIL wrap_addr%0d: got %h expected %h", i, bus2.imem_addr, 32'hFFFF_FFFC + 32'(4 * i)); end
      exp_v = sb.pop_front();
      checks++; if (instr2 !== exp_v.instr || npc2 !== exp_v.npc) begin errors++; $display("FAIL wrap_out%0d: got %h/%h expected %h/%h", i, instr2, npc2, exp_v.instr, exp_v.npc); end
    end
    next_cycle();
    drive(0, 0, 0, 0, 0);
    rst2 = 1'b0;
  endtask

  task automatic test_reset_hold();
    do_reset();
    drive(1, 1, 32'h4444_0000, 0, 0);
    next_cycle();
    drive(1, 0, 0, 0, 0);
    #1;
    checks++; if (bus1.imem_req !== 1'b0 || instr1 !== 32'h4444_0000) begin errors++; $display("FAIL rh_hold: got req %b out %h expected 0/44440000", bus1.imem_req, instr1); end
    rst1 = 1'b0;
    #1;
    checks++; if (bus1.imem_req !== 1'b0 || instr1 !== 32'b0 || npc1 !== 32'b0) begin errors++; $display("FAIL rh_async: got req %b out %h/%h expected 0 0/0", bus1.imem_req, instr1, npc1); end
    next_cycle();
    drive(0, 0, 0, 0, 0);
    rst1 = 1'b1;
    #1;
    checks++; if (bus1.imem_req !== 1'b1 || bus1.imem_addr !== 32'h0) begin errors++; $display("FAIL rh_release: got req %b addr %h expected 1/00000000", bus1.imem_req, bus1.imem_addr); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_hold();
    test_branch_wait();
    test_branch_ack();
    test_discard_branch();
    test_hold_branch();
    test_wrap();
    test_reset_hold();
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_empty: got %0d pending expected 0", sb.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
